// File: rtl/odu_frame_gen_param.sv
// odu_frame_gen_param
//   Parametrised ODU row/frame generator. Client (OSU) words are accepted on a
//   valid/ready handshake into a 2*W_BYTES byte gearbox. Rows of ROW_WORDS
//   words are then emitted. The first word of each row carries OH_BYTES
//   overhead bytes ahead of the payload. The middle words carry payload only.
//   The last word ends with STUFF_BYTES copies of STUFF_BYTE. FS/RS/MFAS
//   sideband accompanies every word.
//
//   Optional build macro: MFAS_INSERT_EN -- when defined, the last overhead
//   byte of every row carries the current mfas value instead of the row
//   pattern byte.
//
// Ports
//   i_clk            clock
//   i_rst_n          synchronous active-low reset
//   i_enable         global run enable (freezes push, emit and state when 0)
//   i_osu_data       client word, first byte at [DATA_W-1 -: 8]
//   i_osu_valid      client word valid
//   o_osu_ready      client word accepted when valid & ready
//   o_odu_data_out   ODU word, MSB-first byte order
//   o_odu_valid_out  ODU word valid
//   o_odu_fs_out     frame start (first word of row 0)
//   o_odu_rs_out     row start (first word of every row)
//   o_odu_mfas_out   multiframe counter of the current word
module odu_frame_gen_param #(
  parameter int          DATA_W         = 384,
  parameter int          OH_BYTES       = 16,
  parameter int          STUFF_BYTES    = 16,
  parameter int          ROW_WORDS      = 81,
  parameter int          ROWS_PER_FRAME = 3,
  parameter logic [7:0]  STUFF_BYTE     = 8'h99
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic [DATA_W-1:0] i_osu_data,
  input  logic              i_osu_valid,
  output logic              o_osu_ready,
  output logic [DATA_W-1:0] o_odu_data_out,
  output logic              o_odu_valid_out,
  output logic              o_odu_fs_out,
  output logic              o_odu_rs_out,
  output logic [7:0]        o_odu_mfas_out
);

  localparam int W_BYTES   = DATA_W / 8;
  localparam int ACC_BYTES = 2 * W_BYTES;
  localparam int FILL_W    = $clog2(ACC_BYTES + 1);
  localparam int WC_W      = $clog2(ROW_WORDS);

  localparam logic [FILL_W-1:0] W_FILL     = FILL_W'(W_BYTES);
  localparam logic [FILL_W-1:0] NEED_OH    = FILL_W'(W_BYTES - OH_BYTES);
  localparam logic [FILL_W-1:0] NEED_END   = FILL_W'(W_BYTES - STUFF_BYTES);
  localparam logic [WC_W-1:0]   WC_PL_LAST = WC_W'(ROW_WORDS - 2);
  localparam logic [3:0]        ROW_LAST   = 4'(ROWS_PER_FRAME - 1);

  typedef enum logic [1:0] {S_IDLE, S_OH, S_PAYLOAD, S_END} state_t;

  state_t                         r_state, w_state_nxt;
  logic [FILL_W-1:0]              r_fill, w_fill_nxt;
  // Accumulator byte 0 is the oldest byte.
  logic [ACC_BYTES-1:0][7:0]      r_acc, w_acc_nxt;
  logic [WC_W-1:0]                r_word_cnt, w_word_cnt_nxt;
  logic [3:0]                     r_row_cnt, w_row_cnt_nxt;
  logic [7:0]                     r_mfas, w_mfas_nxt;

  logic [DATA_W-1:0]              r_data;
  logic                           r_valid, r_fs, r_rs;
  logic [7:0]                     r_mfas_out;

  logic [W_BYTES-1:0][7:0]        w_in;
  logic [W_BYTES-1:0][7:0]        w_word;
  logic [FILL_W-1:0]              w_need, w_pop, w_base;
  logic                           w_emit, w_push;
  logic [3:0]                     w_row_p1;
  logic [7:0]                     w_row_pat;

  assign w_in        = i_osu_data;
  // Ready depends on registered fill only, so it never depends on the emit
  // decision made in the same cycle.
  assign o_osu_ready = i_rst_n & i_enable & (r_fill <= W_FILL);
  assign w_push      = i_osu_valid & o_osu_ready;

  always_comb begin
    w_need = '0;
    case (r_state)
      S_OH:      w_need = NEED_OH;
      S_PAYLOAD: w_need = W_FILL;
      S_END:     w_need = NEED_END;
      default:   w_need = '0;
    endcase
  end

  assign w_emit     = i_enable & (r_state != S_IDLE) & (r_fill >= w_need);
  assign w_pop      = w_emit ? w_need : '0;
  assign w_base     = r_fill - w_pop;
  assign w_fill_nxt = w_base + (w_push ? W_FILL : '0);

  // Gearbox: drop the popped bytes from the head, then append the new client
  // word directly behind the surviving bytes.
  always_comb begin
    w_acc_nxt = '0;
    for (int i = 0; i < ACC_BYTES; i++) begin
      if (i + int'(w_pop) < ACC_BYTES)
        w_acc_nxt[i] = r_acc[i + int'(w_pop)];
    end
    if (w_push) begin
      for (int i = 0; i < ACC_BYTES; i++) begin
        if (i >= int'(w_base) && i < int'(w_base) + W_BYTES)
          w_acc_nxt[i] = w_in[W_BYTES-1-(i-int'(w_base))];
      end
    end
  end

  assign w_row_p1  = r_row_cnt + 4'd1;
  assign w_row_pat = {w_row_p1, w_row_p1};

  // Output word assembly. w_word[W_BYTES-1] is the first (most significant) byte.
  always_comb begin
    w_word = '0;
    for (int b = 0; b < W_BYTES; b++) begin
      case (r_state)
        S_OH: begin
          if (b < OH_BYTES) w_word[W_BYTES-1-b] = w_row_pat;
          else              w_word[W_BYTES-1-b] = r_acc[b-OH_BYTES];
        end
        S_PAYLOAD: w_word[W_BYTES-1-b] = r_acc[b];
        S_END: begin
          if (b < W_BYTES - STUFF_BYTES) w_word[W_BYTES-1-b] = r_acc[b];
          else                           w_word[W_BYTES-1-b] = STUFF_BYTE;
        end
        default: w_word[W_BYTES-1-b] = 8'h00;
      endcase
    end
`ifdef MFAS_INSERT_EN
    if (r_state == S_OH) w_word[W_BYTES-OH_BYTES] = r_mfas;
`endif
  end

  // Row FSM. The only transition that does not need an emit is leaving IDLE.
  always_comb begin
    w_state_nxt    = r_state;
    w_word_cnt_nxt = r_word_cnt;
    w_row_cnt_nxt  = r_row_cnt;
    w_mfas_nxt     = r_mfas;
    case (r_state)
      S_IDLE: if (i_enable) w_state_nxt = S_OH;
      S_OH: if (w_emit) begin
        w_state_nxt    = S_PAYLOAD;
        w_word_cnt_nxt = WC_W'(1);
      end
      S_PAYLOAD: if (w_emit) begin
        if (r_word_cnt == WC_PL_LAST) w_state_nxt = S_END;
        w_word_cnt_nxt = r_word_cnt + WC_W'(1);
      end
      S_END: if (w_emit) begin
        w_state_nxt    = S_OH;
        w_word_cnt_nxt = '0;
        if (r_row_cnt == ROW_LAST) begin
          w_row_cnt_nxt = '0;
          w_mfas_nxt    = r_mfas + 8'd1;
        end else begin
          w_row_cnt_nxt = r_row_cnt + 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_fill     <= '0;
      r_acc      <= '0;
      r_word_cnt <= '0;
      r_row_cnt  <= '0;
      r_mfas     <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_fs       <= 1'b0;
      r_rs       <= 1'b0;
      r_mfas_out <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fill     <= w_fill_nxt;
      r_acc      <= w_acc_nxt;
      r_word_cnt <= w_word_cnt_nxt;
      r_row_cnt  <= w_row_cnt_nxt;
      r_mfas     <= w_mfas_nxt;
      r_valid    <= w_emit;
      r_rs       <= w_emit & (r_state == S_OH);
      r_fs       <= w_emit & (r_state == S_OH) & (r_row_cnt == 4'd0);
      // Data and mfas keep the last emitted word while the output stalls.
      if (w_emit) begin
        r_data     <= w_word;
        r_mfas_out <= r_mfas;
      end
    end
  end

  assign o_odu_data_out  = r_data;
  assign o_odu_valid_out = r_valid;
  assign o_odu_fs_out    = r_fs;
  assign o_odu_rs_out    = r_rs;
  assign o_odu_mfas_out  = r_mfas_out;

endmodule

// File: doc/odu_frame_gen_param.md
Name: odu_frame_gen_param

Overview:
Parametrised ODU row/frame generator, successor to the fixed 384-bit, 3-row generator. It accepts a client (OSU) byte stream over a valid/ready handshake and repacks it through a byte gearbox. It emits rows of ROW_WORDS words: overhead in the first word, payload, and byte stuffing at the tail of the last word. It drives FS/RS/MFAS framing sideband and sits between the OSU packet source and the ODU framer/mux.

Parameters:
DATA_W, 384, word width in bits; multiple of 8; W_BYTES = DATA_W/8
OH_BYTES, 16, overhead bytes at the head of each row's first word; 1..W_BYTES-1
STUFF_BYTES, 16, stuff bytes at the tail of each row's last word; 1..W_BYTES-1
ROW_WORDS, 81, words per row; >= 3
ROWS_PER_FRAME, 3, rows per frame; 1..15
STUFF_BYTE, 8'h99, stuff byte value

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
i_enable  in  1  global run enable
i_osu_data  in  DATA_W  client word, first byte at [DATA_W-1 -: 8]
i_osu_valid  in  1  client word valid
o_osu_ready  out  1  client word accepted when valid & ready
o_odu_data_out  out  DATA_W  ODU word, MSB-first byte order
o_odu_valid_out  out  1  ODU word valid
o_odu_fs_out  out  1  frame start: first word of row 0
o_odu_rs_out  out  1  row start: first word of every row
o_odu_mfas_out  out  8  multiframe counter of the current word

Behaviour:
- Reset and clock: one clock i_clk; reset i_rst_n is synchronous, active-low. While i_rst_n=0: all outputs 0; state IDLE; row, word and mfas counters 0; accumulator fill 0 (contents discarded). The same applies to a reset mid-row.
- Accumulator: 2*W_BYTES bytes with fill count 0..2*W_BYTES.
  - o_osu_ready = i_enable & (fill <= W_BYTES), decoded from registered fill.
  - Push and pop may occur in the same cycle: fill_next = fill - pop + (push ? W_BYTES : 0).
- Per-word payload need:
  - first word: W_BYTES-OH_BYTES
  - middle words: W_BYTES
  - last word: W_BYTES-STUFF_BYTES
  - payload per row: ROW_WORDS*W_BYTES-OH_BYTES-STUFF_BYTES
- FSM states: IDLE, OH, PAYLOAD, END.
  - IDLE -> OH when i_enable=1.
  - OH -> PAYLOAD.
  - PAYLOAD -> END after the emit with word_cnt==ROW_WORDS-2.
  - END -> OH, with row_cnt+1 wrapping at ROWS_PER_FRAME.
  - On the row wrap, mfas increments modulo 256 (255 -> 0).
  - Counters and state advance only on an emit.
- Emit condition: i_enable=1 & state!=IDLE & fill >= need of the current word.
  - If fill < need: no emit; o_odu_valid_out=0 next cycle; state, counters and accumulator hold. Output stalls rather than inserting filler.
- Output registered, 1-cycle latency from the emit decision. On the clock following an emit:
  - o_odu_valid_out=1
  - o_odu_data_out holds the word
  - o_odu_rs_out=1 for OH words
  - o_odu_fs_out=1 for OH words when row_cnt==0
  - o_odu_mfas_out = mfas of that word
- Otherwise valid/fs/rs=0; data and mfas hold their last value.
- Word layout:
  - OH word: OH_BYTES overhead bytes, each {row_cnt+1 [3:0], row_cnt+1 [3:0]} (row 0 = 8'h11), followed by the oldest payload bytes.
  - PAYLOAD word: W_BYTES oldest bytes.
  - END word: oldest payload bytes, then STUFF_BYTES copies of STUFF_BYTE.
- i_enable=0: no push, no emit, state frozen; fill preserved. Resumes seamlessly when re-enabled.

Optional Feature:
MFAS_INSERT_EN
- Defined: the last OH byte of every row carries the current mfas value instead of the row pattern byte.
- Undefined: all OH bytes carry the row pattern.
- Data otherwise identical in both builds.

Test Plan:
All scenarios use DATA_W=64, OH=2, STUFF=2, ROW_WORDS=4, ROWS=2. Client bytes are incrementing from 8'h00, and i_osu_valid is always 1 unless stated.
- Row 0 content -> words 1111_0001_0203_0405, 0607_..._0D, 0E0F_..._15, 1617_1819_1A1B_9999; fs=rs=1 on word 1 only; mfas=0.
- Row 1 content -> first word 2222_1C1D_1E1F_2021, rs=1, fs=0; after row 1 the next OH word is 8'h11-prefixed, fs=1, mfas=1.
- Input stalls: i_osu_valid=0 for 5 cycles mid-row -> o_odu_valid_out drops once fill < 8; payload continues gaplessly afterwards; no byte lost or duplicated.
- i_enable=0 for 3 cycles mid-row -> no valid output, o_osu_ready=0; sequence resumes identically after re-enable.
- i_rst_n=0 mid-row for 1 cycle -> all outputs 0 next cycle; restart emits 1111_0001... using the next fresh client bytes, mfas=0.
- MFAS wrap: run 256 frames -> mfas 255 then 0 with fs=1. With MFAS_INSERT_EN, the OH word of frame 5 is 1105_... in row 0 and 2205_... in row 1.
